// File: rtl/pc_next_control_if.sv
// Bus between decode/branch logic and the next-PC selector.
// With PC_IRQ_COUNT_EN defined, also carries the handler-entry counter.
interface pc_next_control_if;
  logic [31:0] programCounter;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic        interrupt;
  logic        eret;
  logic [31:0] address;
  logic [31:0] epc;
  logic        in_handler;
  logic        int_pending;
  logic        int_ack;
`ifdef PC_IRQ_COUNT_EN
  logic [15:0] irq_count;
`endif

  modport master (
    output programCounter, stall, branch_taken, branch_offset, jump, jump_target,
           jump_reg, reg_target, interrupt, eret,
`ifdef PC_IRQ_COUNT_EN
    input  irq_count,
`endif
    input  address, epc, in_handler, int_pending, int_ack
  );

  modport slave (
    input  programCounter, stall, branch_taken, branch_offset, jump, jump_target,
           jump_reg, reg_target, interrupt, eret,
`ifdef PC_IRQ_COUNT_EN
    output irq_count,
`endif
    output address, epc, in_handler, int_pending, int_ack
  );
endinterface

// File: rtl/pc_next_control.sv
// Next-PC selector: sequential/branch/jump, stall hold, interrupt entry and eret via saved EPC.
// Optional PC_IRQ_COUNT_EN adds a saturating count of handler entries.
module pc_next_control #(
  parameter logic [31:0] BOOT0_ADDR = 32'd0,
  parameter logic [31:0] BOOT1_ADDR = 32'd11,
  parameter logic [31:0] INT_VECTOR = 32'd4,
  parameter logic [31:0] PC_STEP    = 32'd1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                program_sel,
  pc_next_control_if.slave    bus
);

  typedef enum logic [0:0] {StRun, StHandler} state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic        pending_q, pending_d;
  logic        irq_q;
  logic [31:0] nn;
  logic        rise, take, ret;
  logic [31:0] address;

  always_comb begin
    nn        = bus.programCounter + PC_STEP;
    state_d   = state_q;
    epc_d     = epc_q;
    pending_d = pending_q;
    address   = nn;

    if (bus.jump_reg) begin
      nn = bus.reg_target;
    end else if (bus.jump) begin
      nn = {bus.programCounter[31:26], bus.jump_target};
    end else if (bus.branch_taken) begin
      nn = bus.programCounter + PC_STEP + bus.branch_offset;
    end

    rise = bus.interrupt & ~irq_q;
    take = !reset && !bus.stall && (state_q == StRun) && pending_q;
    ret  = !reset && !bus.stall && (state_q == StHandler) && bus.eret;

    // A fresh edge on the entry cycle must survive the clear.
    pending_d = (pending_q & ~take) | rise;

    if (take) begin
      state_d = StHandler;
      epc_d   = nn;
    end else if (ret) begin
      state_d = StRun;
    end

    if (reset) begin
      address = program_sel ? BOOT1_ADDR : BOOT0_ADDR;
    end else if (bus.stall) begin
      address = bus.programCounter;
    end else if (take) begin
      address = INT_VECTOR;
    end else if (ret) begin
      address = epc_q;
    end else begin
      address = nn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StRun;
      epc_q     <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      pending_q <= pending_d;
      irq_q     <= bus.interrupt;
    end
  end

  assign bus.address     = address;
  assign bus.epc         = epc_q;
  assign bus.in_handler  = (state_q == StHandler);
  assign bus.int_pending = pending_q;
  assign bus.int_ack     = take;

`ifdef PC_IRQ_COUNT_EN
  logic [15:0] irq_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_count_q <= 16'd0;
    end else if (take && (irq_count_q != 16'hFFFF)) begin
      irq_count_q <= irq_count_q + 16'd1;
    end
  end

  assign bus.irq_count = irq_count_q;
`endif

endmodule

// File: doc/pc_next_control.md
Name: pc_next_control

Overview:
- Produces the next-address input for the program counter register every cycle.
- Handles:
  - sequential fetch (word-addressed, +1)
  - conditional branch, absolute jump, register jump
  - pipeline stall hold
  - interrupt entry/return with a saved exception PC (EPC)
- Sits between the decode/branch logic and the PC register.
- Its `address` output drives the PC register's `address` input. The PC register's `programCounter` output feeds back into this block.

Parameters:
- BOOT0_ADDR, 32'd0, address selected during reset when program=0
- BOOT1_ADDR, 32'd11, address selected during reset when program=1
- INT_VECTOR, 32'd4, handler entry address
- PC_STEP, 32'd1, sequential increment (word addressing)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- program  in  1  boot image select, same meaning as the PC register's input
- programCounter  in  32  current PC value
- stall  in  1  hold current PC
- branch_taken  in  1  take conditional branch
- branch_offset  in  32  signed word offset, already sign-extended
- jump  in  1  absolute jump
- jump_target  in  26  jump index
- jump_reg  in  1  register jump
- reg_target  in  32  register jump address
- interrupt  in  1  external interrupt request, level input, rising-edge detected
- eret  in  1  return from handler
- address  out  32  next PC, combinational from state, registers and inputs
- epc  out  32  saved return address
- in_handler  out  1  FSM is in HANDLER
- int_pending  out  1  latched, not yet serviced interrupt
- int_ack  out  1  one-cycle pulse on the cycle the handler is entered

Behaviour:
- Reset:
  - address = program ? BOOT1_ADDR : BOOT0_ADDR while reset=1.
  - At the clock edge: state=RUN, epc=0, int_pending=0, int_ack=0, interrupt edge-detect register=0.
- FSM has two states: RUN and HANDLER. in_handler = (state==HANDLER).
- Edge detect:
  - `interrupt` is registered each cycle.
  - A 0->1 transition sets int_pending at the next edge, in any state, including during stall.
  - int_pending stays set until serviced.
- "Normal next" value (nn), by priority:
  1. jump_reg: reg_target
  2. jump: {programCounter[31:26], jump_target}
  3. branch_taken: programCounter + PC_STEP + branch_offset
  4. otherwise: programCounter + PC_STEP
  - All arithmetic is 32-bit modulo 2^32. 32'hFFFFFFFF + 1 wraps to 0.
- Selection priority:
  1. reset
  2. stall: address = programCounter; no state, epc, pending or ack change. Requests stay latched.
  3. state RUN and int_pending:
     - address = INT_VECTOR
     - at the edge: epc <= nn, int_pending <= 0, state <= HANDLER, int_ack = 1 for this cycle only
     - the branch or jump is preserved in epc
  4. state HANDLER and eret: address = epc; state <= RUN at the edge.
  5. else: address = nn.
- eret in RUN is ignored; address = nn.
- Interrupt edges arriving in HANDLER set int_pending but are not taken (no nesting). The first one is serviced on the first non-stalled RUN cycle after eret.
- Same-cycle edge and entry: the new edge re-sets int_pending. Set wins over clear.
- Reset mid-handler aborts to RUN immediately. Any pending interrupt is discarded.
- Latency:
  - interrupt edge -> int_pending: 1 cycle
  - int_pending -> vector on `address`: same cycle, when RUN and not stalled

Optional Feature:
- Macro: PC_IRQ_COUNT_EN.
- When defined:
  - Adds output `irq_count` [15:0]: number of handler entries.
  - Increments on each int_ack and saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: no port and no counter. All other behaviour is identical.

Test Plan:
- Reset, program=1 -> address=11 during reset. After release with programCounter=11 and no controls -> address=12.
- programCounter=32'h100, branch_taken=1, branch_offset=-2 -> address=32'hFF. With jump_reg=1 and reg_target=32'h40 also asserted -> address=32'h40.
- Interrupt pulse with stall=1 for 3 cycles -> int_pending=1 and address=programCounter throughout. On stall=0 with programCounter=32'h20 -> address=4, int_ack=1 for one cycle, epc=32'h21, in_handler=1.
- In HANDLER, second interrupt edge, then eret with epc=32'h21 -> address=32'h21, state RUN. On the next cycle -> address=4 and int_ack=1 again.
- Reset asserted while in_handler=1 and int_pending=1 -> next cycle in_handler=0, int_pending=0, epc=0.
- PC_IRQ_COUNT_EN: 3 serviced interrupts -> irq_count=3. After reset -> 0.
